pipe_hazard_unit: RTL and testbench

PIPE_HAZARD_UNIT -- requirements
Module: pipe_hazard_unit

---
 rtl/pipe_hazard_unit_if.sv | 44 ++++
 rtl/pipe_hazard_unit.sv | 140 ++++++++++++++
 tb/tb_pipe_hazard_unit.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_unit_if.sv
// ID-stage hazard bundle: decoded ID operands, per-stage results and RF data in,
// stall / forwarding selects / resolved operands / perf counters out.
interface pipe_hazard_unit_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int STAGES = 3
);
    localparam int SEL_W = $clog2(STAGES + 1);

    logic                     id_valid;
    logic [REG_AW-1:0]        id_rs;
    logic [REG_AW-1:0]        id_rt;
    logic                     id_rs_used;
    logic                     id_rt_used;
    logic [REG_AW-1:0]        id_rc;
    logic                     id_regwr;
    logic                     id_memrd;
    logic                     flush;
    logic [STAGES*DATA_W-1:0] stage_data;
    logic [DATA_W-1:0]        rf_rs_data;
    logic [DATA_W-1:0]        rf_rt_data;

    logic                     stall;
    logic [SEL_W-1:0]         fwd_rs_sel;
    logic [SEL_W-1:0]         fwd_rt_sel;
    logic [DATA_W-1:0]        fwd_rs_data;
    logic [DATA_W-1:0]        fwd_rt_data;
    logic [31:0]              stall_cnt;
    logic [31:0]              fwd_cnt;

    modport master (
        output id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_rc,
               id_regwr, id_memrd, flush, stage_data, rf_rs_data, rf_rt_data,
        input  stall, fwd_rs_sel, fwd_rt_sel, fwd_rs_data, fwd_rt_data,
               stall_cnt, fwd_cnt
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_rc,
               id_regwr, id_memrd, flush, stage_data, rf_rs_data, rf_rt_data,
        output stall, fwd_rs_sel, fwd_rt_sel, fwd_rs_data, fwd_rt_data,
               stall_cnt, fwd_cnt
    );
endinterface

// File: rtl/pipe_hazard_unit.sv
// Pipeline hazard unit: destination scoreboard, load-use stall and operand forwarding.
// Optional performance counters are built only when PIPE_HAZARD_PERF_EN is defined.
module pipe_hazard_unit #(
    parameter int DATA_W     = 32,
    parameter int REG_AW     = 5,
    parameter int STAGES     = 3,
    parameter int LOAD_STAGE = 1
) (
    input  logic              clk,
    input  logic              reset,
    pipe_hazard_unit_if.slave bus
);
    localparam int SEL_W = $clog2(STAGES + 1);

    logic [STAGES-1:0] valid_q, valid_d;
    logic [STAGES-1:0] regwr_q, regwr_d;
    logic [REG_AW-1:0] rc_q  [STAGES];
    logic [REG_AW-1:0] rc_d  [STAGES];
    logic [SEL_W-1:0]  rdy_q [STAGES];
    logic [SEL_W-1:0]  rdy_d [STAGES];

    logic [REG_AW-1:0] op_addr [2];
    logic              op_used [2];
    logic [DATA_W-1:0] op_rf   [2];
    logic [SEL_W-1:0]  op_sel  [2];
    logic              op_haz  [2];
    logic [DATA_W-1:0] op_data [2];
    logic              stall_w;

    assign op_addr[0] = bus.id_rs;
    assign op_addr[1] = bus.id_rt;
    assign op_used[0] = bus.id_rs_used;
    assign op_used[1] = bus.id_rt_used;
    assign op_rf[0]   = bus.rf_rs_data;
    assign op_rf[1]   = bus.rf_rt_data;

    // Scan oldest to youngest so the youngest matching writer overrides.
    always_comb begin
        for (int op = 0; op < 2; op++) begin
            op_sel[op] = '0;
            op_haz[op] = 1'b0;
            if (op_used[op] && (op_addr[op] != '0)) begin
                for (int k = STAGES - 1; k >= 0; k--) begin
                    if (valid_q[k] && regwr_q[k] && (rc_q[k] == op_addr[op])) begin
                        if (k < int'(rdy_q[k])) begin
                            op_haz[op] = 1'b1;
                            op_sel[op] = '0;
                        end else begin
                            op_haz[op] = 1'b0;
                            op_sel[op] = SEL_W'(k + 1);
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        for (int op = 0; op < 2; op++) begin
            op_data[op] = op_rf[op];
            for (int k = 0; k < STAGES; k++) begin
                if (op_sel[op] == SEL_W'(k + 1)) begin
                    op_data[op] = bus.stage_data[k*DATA_W +: DATA_W];
                end
            end
        end
    end

    assign stall_w = (op_haz[0] | op_haz[1]) & bus.id_valid & ~bus.flush;

    assign bus.stall       = stall_w;
    assign bus.fwd_rs_sel  = op_sel[0];
    assign bus.fwd_rt_sel  = op_sel[1];
    assign bus.fwd_rs_data = op_data[0];
    assign bus.fwd_rt_data = op_data[1];

    // A stalled or flushed ID slot enters the pipe as a bubble.
    always_comb begin
        valid_d[0] = bus.id_valid & ~stall_w & ~bus.flush;
        regwr_d[0] = bus.id_regwr;
        rc_d[0]    = bus.id_rc;
        rdy_d[0]   = bus.id_memrd ? SEL_W'(LOAD_STAGE) : '0;
        for (int k = 1; k < STAGES; k++) begin
            valid_d[k] = valid_q[k-1];
            regwr_d[k] = regwr_q[k-1];
            rc_d[k]    = rc_q[k-1];
            rdy_d[k]   = rdy_q[k-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_q <= '0;
            regwr_q <= '0;
            rc_q    <= '{default: '0};
            rdy_q   <= '{default: '0};
        end else begin
            valid_q <= valid_d;
            regwr_q <= regwr_d;
            rc_q    <= rc_d;
            rdy_q   <= rdy_d;
        end
    end

`ifdef PIPE_HAZARD_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] fwd_cnt_q, fwd_cnt_d;
    logic        fwd_hit;

    assign fwd_hit = bus.id_valid & ~stall_w & ((op_sel[0] != '0) | (op_sel[1] != '0));

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        fwd_cnt_d   = fwd_cnt_q;
        if (stall_w && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (fwd_hit && (fwd_cnt_q != 32'hFFFF_FFFF)) begin
            fwd_cnt_d = fwd_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cnt_q <= '0;
            fwd_cnt_q   <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            fwd_cnt_q   <= fwd_cnt_d;
        end
    end

    assign bus.stall_cnt = stall_cnt_q;
    assign bus.fwd_cnt   = fwd_cnt_q;
`else
    assign bus.stall_cnt = 32'd0;
    assign bus.fwd_cnt   = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Directed + randomized bench for pipe_hazard_unit; expected results go through a scoreboard queue.
module tb_pipe_hazard_unit;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int ST = 3;
    localparam int LS = 1;
`ifdef PIPE_HAZARD_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif
    localparam logic [31:0] RFS = 32'hAAAA_0000;
    localparam logic [31:0] RFT = 32'hBBBB_0000;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pipe_hazard_unit_if #(.DATA_W(DW), .REG_AW(AW), .STAGES(ST)) bus ();

    pipe_hazard_unit #(.DATA_W(DW), .REG_AW(AW), .STAGES(ST), .LOAD_STAGE(LS)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        string       tag;
        logic        stall;
        bit          rs_care;
        int          rs_sel;
        logic [31:0] rs_data;
        bit          rt_care;
        int          rt_sel;
        logic [31:0] rt_data;
        bit          cnt_care;
        int          scnt;
        int          fcnt;
    } exp_t;

    exp_t        sb[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] sd [ST];

    bit m_v [ST];
    bit m_w [ST];
    int m_rc[ST];
    int m_rdy[ST];

    assign bus.stage_data = {sd[2], sd[1], sd[0]};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cmp(input string tag, input string fld, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s.%s observed=%0h expected=%0h", tag, fld, obs, exp);
        end
    endtask

    task automatic drive(input bit v, input int rs, input bit rsu, input int rt, input bit rtu,
                         input int rc, input bit wr, input bit ld, input bit fl);
        bus.id_valid   = v;
        bus.id_rs      = AW'(rs);
        bus.id_rs_used = rsu;
        bus.id_rt      = AW'(rt);
        bus.id_rt_used = rtu;
        bus.id_rc      = AW'(rc);
        bus.id_regwr   = wr;
        bus.id_memrd   = ld;
        bus.flush      = fl;
    endtask

    task automatic push(input string tag, input bit st,
                        input bit rsc, input int rss, input logic [31:0] rsd,
                        input bit rtc, input int rts, input logic [31:0] rtd,
                        input bit cc, input int sc, input int fc);
        exp_t e;
        e.tag = tag; e.stall = st;
        e.rs_care = rsc; e.rs_sel = rss; e.rs_data = rsd;
        e.rt_care = rtc; e.rt_sel = rts; e.rt_data = rtd;
        e.cnt_care = cc; e.scnt = sc; e.fcnt = fc;
        sb.push_back(e);
    endtask

    task automatic check();
        exp_t e;
        #2;
        if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $error("FAIL scoreboard observed=empty expected=entry");
        end else begin
            e = sb.pop_front();
            cmp(e.tag, "stall", 32'(bus.stall), 32'(e.stall));
            if (e.rs_care) begin
                cmp(e.tag, "rs_sel", 32'(bus.fwd_rs_sel), 32'(e.rs_sel));
                cmp(e.tag, "rs_data", bus.fwd_rs_data, e.rs_data);
            end
            if (e.rt_care) begin
                cmp(e.tag, "rt_sel", 32'(bus.fwd_rt_sel), 32'(e.rt_sel));
                cmp(e.tag, "rt_data", bus.fwd_rt_data, e.rt_data);
            end
            if (e.cnt_care) begin
                cmp(e.tag, "stall_cnt", bus.stall_cnt, 32'(e.scnt));
                cmp(e.tag, "fwd_cnt", bus.fwd_cnt, 32'(e.fcnt));
            end
        end
    endtask

    // Reference lookup: first match scanning from the youngest entry.
    task automatic model_op(input int addr, input bit used, output bit haz, output int sel);
        bit found;
        int kk;
        found = 1'b0; kk = 0; haz = 1'b0; sel = 0;
        if (used && addr != 0) begin
            for (int k = 0; k < ST; k++) begin
                if (!found && m_v[k] && m_w[k] && m_rc[k] == addr) begin
                    found = 1'b1;
                    kk = k;
                end
            end
        end
        if (found) begin
            if (kk < m_rdy[kk]) haz = 1'b1;
            else sel = kk + 1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        sd[0] = 32'h0000_1234; sd[1] = 32'h5555_0001; sd[2] = 32'h7777_0002;
        bus.rf_rs_data = RFS;
        bus.rf_rt_data = RFT;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        tick(); tick();

        drive(1, 5, 1, 6, 1, 0, 0, 0, 0);
        push("reset", 0, 1, 0, RFS, 1, 0, RFT, 1, 0, 0); check();
        reset = 1'b1;
        tick();

        drive(1, 0, 0, 0, 0, 8, 1, 0, 0);
        push("alu_wr", 0, 1, 0, RFS, 1, 0, RFT, 0, 0, 0); check(); tick();
        drive(1, 8, 1, 0, 0, 0, 0, 0, 0);
        push("alu_fwd", 0, 1, 1, 32'h0000_1234, 1, 0, RFT, 0, 0, 0); check(); tick();
        push("mem_fwd", 0, 1, 2, 32'h5555_0001, 1, 0, RFT, 0, 0, 0); check(); tick();
        push("wb_fwd", 0, 1, 3, 32'h7777_0002, 1, 0, RFT, 0, 0, 0); check(); tick();
        push("retired", 0, 1, 0, RFS, 1, 0, RFT, 0, 0, 0); check(); tick();

        drive(1, 0, 0, 0, 0, 9, 1, 1, 0);
        push("load9", 0, 1, 0, RFS, 1, 0, RFT, 0, 0, 0); check(); tick();
        drive(1, 0, 0, 9, 1, 0, 0, 0, 0);
        push("lu_stall", 1, 1, 0, RFS, 0, 0, 0, 0, 0, 0); check(); tick();
        push("lu_fwd", 0, 1, 0, RFS, 1, 2, 32'h5555_0001, 0, 0, 0); check(); tick();

        drive(1, 0, 0, 0, 0, 10, 1, 0, 0);
        push("w10a", 0, 1, 0, RFS, 1, 0, RFT, 0, 0, 0); check(); tick();
        drive(1, 0, 0, 0, 0, 10, 0, 0, 0);
        push("filler", 0, 1, 0, RFS, 1, 0, RFT, 0, 0, 0); check(); tick();
        drive(1, 10, 1, 0, 0, 10, 1, 0, 0);
        push("no_regwr", 0, 1, 2, 32'h5555_0001, 1, 0, RFT, 0, 0, 0); check(); tick();
        sd[0] = 32'h0000_000A; sd[2] = 32'h0000_000B;
        drive(1, 10, 1, 10, 0, 0, 0, 0, 0);
        push("youngest", 0, 1, 1, 32'h0000_000A, 1, 0, RFT, 0, 0, 0); check(); tick();

        drive(1, 0, 0, 0, 0, 0, 1, 0, 0);
        push("w_r0", 0, 1, 0, RFS, 1, 0, RFT, 0, 0, 0); check(); tick();
        bus.rf_rs_data = 32'h0;
        drive(1, 0, 1, 10, 1, 0, 0, 0, 0);
        push("reg0", 0, 1, 0, 32'h0, 1, 3, 32'h0000_000B, 0, 0, 0); check(); tick();
        bus.rf_rs_data = RFS;
        sd[0] = 32'h0000_1234; sd[2] = 32'h7777_0002;

        drive(1, 0, 0, 0, 0, 11, 1, 1, 0);
        push("ld11", 0, 1, 0, RFS, 1, 0, RFT, 0, 0, 0); check(); tick();
        drive(1, 11, 1, 0, 0, 12, 1, 0, 1);
        push("flush", 0, 0, 0, 0, 1, 0, RFT, 0, 0, 0); check(); tick();
        drive(1, 12, 1, 11, 1, 0, 0, 0, 0);
        push("post_flush", 0, 1, 0, RFS, 1, 2, 32'h5555_0001, 0, 0, 0); check(); tick();

        drive(1, 0, 0, 0, 0, 13, 1, 1, 0);
        push("ld13", 0, 1, 0, RFS, 1, 0, RFT, 0, 0, 0); check(); tick();
        drive(0, 13, 1, 0, 0, 0, 0, 0, 0);
        push("no_valid", 0, 0, 0, 0, 1, 0, RFT, 0, 0, 0); check(); tick();
        drive(1, 13, 1, 0, 0, 0, 0, 0, 0);
        push("nv_fwd", 0, 1, 2, 32'h5555_0001, 1, 0, RFT, 0, 0, 0); check(); tick();

        // Reset during a load-use stall after two counted stalls.
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        reset = 1'b1;
        push("rst2", 0, 1, 0, RFS, 1, 0, RFT, 1, 0, 0); check(); tick();
        drive(1, 0, 0, 0, 0, 20, 1, 1, 0);
        push("ld20", 0, 1, 0, RFS, 1, 0, RFT, 1, 0, 0); check(); tick();
        drive(1, 20, 1, 0, 0, 0, 0, 0, 0);
        push("cnt_st1", 1, 0, 0, 0, 1, 0, RFT, 1, 0, 0); check(); tick();
        drive(1, 20, 1, 0, 0, 21, 1, 1, 0);
        push("cnt_fw1", 0, 1, 2, 32'h5555_0001, 1, 0, RFT, 1, PERF ? 1 : 0, 0); check(); tick();
        drive(1, 21, 1, 0, 0, 0, 0, 0, 0);
        push("cnt_st2", 1, 0, 0, 0, 1, 0, RFT, 1, PERF ? 1 : 0, PERF ? 1 : 0); check(); tick();
        drive(1, 21, 1, 0, 0, 22, 1, 1, 0);
        push("cnt_fw2", 0, 1, 2, 32'h5555_0001, 1, 0, RFT, 1, PERF ? 2 : 0, PERF ? 1 : 0); check(); tick();
        drive(1, 0, 0, 22, 1, 0, 0, 0, 0);
        reset = 1'b0;
        push("rst_stall", 1, 1, 0, RFS, 0, 0, 0, 1, PERF ? 2 : 0, PERF ? 2 : 0); check(); tick();
        reset = 1'b1;
        push("rst_release", 0, 1, 0, RFS, 1, 0, RFT, 1, 0, 0); check(); tick();

        // Randomized traffic against the reference scoreboard model.
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        reset = 1'b1;
        for (int k = 0; k < ST; k++) begin
            m_v[k] = 1'b0; m_w[k] = 1'b0; m_rc[k] = 0; m_rdy[k] = 0;
        end
        for (int i = 0; i < 300; i++) begin
            bit v, rsu, rtu, wr, ld, fl, hs, ht, est;
            int rs, rt, rc, ss, ts;
            logic [31:0] ers, ert;
            v   = ($urandom_range(3) != 0);
            rs  = $urandom_range(3);
            rt  = $urandom_range(3);
            rc  = $urandom_range(3);
            rsu = $urandom_range(1);
            rtu = $urandom_range(1);
            wr  = ($urandom_range(3) != 0);
            ld  = ($urandom_range(2) == 0);
            fl  = ($urandom_range(7) == 0);
            for (int k = 0; k < ST; k++) sd[k] = $urandom;
            bus.rf_rs_data = $urandom;
            bus.rf_rt_data = $urandom;
            drive(v, rs, rsu, rt, rtu, rc, wr, ld, fl);
            model_op(rs, rsu, hs, ss);
            model_op(rt, rtu, ht, ts);
            est = (hs | ht) & v & ~fl;
            ers = (ss == 0) ? bus.rf_rs_data : sd[ss-1];
            ert = (ts == 0) ? bus.rf_rt_data : sd[ts-1];
            push("rand", est, !hs, ss, ers, !ht, ts, ert, 0, 0, 0);
            check();
            for (int k = ST - 1; k > 0; k--) begin
                m_v[k] = m_v[k-1]; m_w[k] = m_w[k-1]; m_rc[k] = m_rc[k-1]; m_rdy[k] = m_rdy[k-1];
            end
            m_v[0]   = v & ~est & ~fl;
            m_w[0]   = wr;
            m_rc[0]  = rc;
            m_rdy[0] = ld ? LS : 0;
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
